ysyx_23060124_idu_pipe: RTL and testbench

//  Registered RV32I/E decode stage between IFU and EXU, with valid/ready handshakes on both sides.
//  - Decodes the instruction into operand fields, immediate, ALU opt, source select and a packed control bus.
//  - Holds results in a 2-entry output buffer (main + skid) so in_ready is driven from a flop; full throughput under no stall.
//  - Register-index width is parametrised (RV32E/RV32I); adds flush and pc pass-through.

---
 rtl/ysyx_23060124_idu_pipe_if.sv | 36 +++
 rtl/ysyx_23060124_idu_pipe.sv | 188 ++++++++++++++++++
 tb/tb_ysyx_23060124_idu_pipe.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060124_idu_pipe_if.sv
// IFU -> IDU -> EXU handshake and decoded-bundle bus for ysyx_23060124_idu_pipe.
// The slave modport is the decode stage's view; the master is the surrounding IFU/EXU side.
interface ysyx_23060124_idu_pipe_if #(
  parameter int unsigned REG_W = 4,
  parameter int unsigned PC_W  = 32
);
  logic             i_flush;
  logic             i_valid;
  logic             o_ready;
  logic [31:0]      i_ins;
  logic [PC_W-1:0]  i_pc;
  logic             o_valid;
  logic             i_ready;
  logic [PC_W-1:0]  o_pc;
  logic [31:0]      o_imm;
  logic [REG_W-1:0] o_rd;
  logic [REG_W-1:0] o_rs1;
  logic [REG_W-1:0] o_rs2;
  logic [11:0]      o_csr_addr;
  logic [2:0]       o_exu_opt;
  logic [1:0]       o_src_sel;
  logic [11:0]      o_ctrl;
  logic             o_illegal;

  modport slave (
    input  i_flush, i_valid, i_ins, i_pc, i_ready,
    output o_ready, o_valid, o_pc, o_imm, o_rd, o_rs1, o_rs2, o_csr_addr, o_exu_opt,
           o_src_sel, o_ctrl, o_illegal
  );

  modport master (
    output i_flush, i_valid, i_ins, i_pc, i_ready,
    input  o_ready, o_valid, o_pc, o_imm, o_rd, o_rs1, o_rs2, o_csr_addr, o_exu_opt,
           o_src_sel, o_ctrl, o_illegal
  );
endinterface

// File: rtl/ysyx_23060124_idu_pipe.sv
// Registered RV32I/E decode stage with a main + skid output buffer so o_ready comes from a flop.
// Define IDU_ILLEGAL_CHK_EN to flag unsupported/out-of-range encodings on o_illegal.
module ysyx_23060124_idu_pipe #(
  parameter int unsigned REG_W = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  ysyx_23060124_idu_pipe_if.slave  bus
);

  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpImm     = 7'b0010011;
  localparam logic [6:0] OpReg     = 7'b0110011;
  localparam logic [6:0] OpMiscMem = 7'b0001111;
  localparam logic [6:0] OpSystem  = 7'b1110011;

  localparam logic [1:0] SelReg   = 2'b00;
  localparam logic [1:0] SelImm   = 2'b01;
  localparam logic [1:0] SelPc4   = 2'b10;
  localparam logic [1:0] SelPcImm = 2'b11;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [31:0]      imm;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [11:0]      csr_addr;
    logic [2:0]       exu_opt;
    logic [1:0]       src_sel;
    logic [11:0]      ctrl;
    logic             illegal;
  } bundle_t;

  logic [31:0] ins;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        f7b5;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        no_rs1, use_rs2;
  bundle_t     dec;

  assign ins    = bus.i_ins;
  assign opcode = ins[6:0];
  assign funct3 = ins[14:12];
  assign f7b5   = ins[30];
  assign imm_i  = {{20{ins[31]}}, ins[31:20]};
  assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u  = {ins[31:12], 12'b0};
  assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  always_comb begin
    dec         = '0;
    no_rs1      = 1'b0;
    use_rs2     = 1'b0;
    dec.pc      = bus.i_pc;
    dec.rd      = ins[7+:REG_W];
    unique case (opcode)
      OpLui: begin
        no_rs1 = 1'b1; dec.imm = imm_u; dec.src_sel = SelImm; dec.ctrl[0] = 1'b1;
      end
      OpAuipc: begin
        no_rs1 = 1'b1; dec.imm = imm_u; dec.src_sel = SelPcImm; dec.ctrl[0] = 1'b1;
      end
      OpJal: begin
        no_rs1 = 1'b1; dec.imm = imm_j; dec.src_sel = SelPc4;
        dec.ctrl[0] = 1'b1; dec.ctrl[8] = 1'b1;
      end
      OpJalr: begin
        dec.imm = imm_i; dec.exu_opt = funct3; dec.src_sel = SelPc4;
        dec.ctrl[0] = 1'b1; dec.ctrl[9] = 1'b1;
      end
      OpBranch: begin
        use_rs2 = 1'b1; dec.imm = imm_b; dec.exu_opt = funct3; dec.src_sel = SelReg;
        dec.ctrl[7] = 1'b1;
      end
      OpLoad: begin
        dec.imm = imm_i; dec.exu_opt = funct3; dec.src_sel = SelImm;
        dec.ctrl[0] = 1'b1; dec.ctrl[5] = 1'b1;
      end
      OpStore: begin
        use_rs2 = 1'b1; dec.imm = imm_s; dec.exu_opt = funct3; dec.src_sel = SelImm;
        dec.ctrl[6] = 1'b1;
      end
      OpImm: begin
        dec.imm = imm_i; dec.exu_opt = funct3; dec.src_sel = SelImm; dec.ctrl[0] = 1'b1;
        dec.ctrl[2] = f7b5 && (funct3 == 3'b101);
      end
      OpReg: begin
        use_rs2 = 1'b1; dec.exu_opt = funct3; dec.src_sel = SelReg; dec.ctrl[0] = 1'b1;
        dec.ctrl[2] = f7b5 && ((funct3 == 3'b101) || (funct3 == 3'b000));
      end
      OpMiscMem: begin
        dec.ctrl[11] = (funct3 == 3'b001);
      end
      OpSystem: begin
        dec.csr_addr = ins[31:20];
        if (funct3 == 3'b000) begin
          // rs2 field selects the privileged op
          dec.ctrl[4]  = (ins[21:20] == 2'b00);
          dec.ctrl[10] = (ins[21:20] == 2'b01);
          dec.ctrl[3]  = (ins[21:20] == 2'b10);
        end else begin
          dec.ctrl[0]   = 1'b1;
          dec.ctrl[1]   = 1'b1;
          dec.exu_opt   = (funct3 == 3'b010) ? 3'b110 : 3'b000;
        end
      end
      default: ;
    endcase
    dec.rs1 = no_rs1 ? '0 : ins[15+:REG_W];
    dec.rs2 = use_rs2 ? ins[20+:REG_W] : '0;
    if (dec.rd == '0) dec.ctrl[0] = 1'b0;
`ifdef IDU_ILLEGAL_CHK_EN
    begin
      logic known, use_rd, bad_reg;
      known   = (opcode == OpLui) || (opcode == OpAuipc) || (opcode == OpJal) ||
                (opcode == OpJalr) || (opcode == OpBranch) || (opcode == OpLoad) ||
                (opcode == OpStore) || (opcode == OpImm) || (opcode == OpReg) ||
                (opcode == OpMiscMem) || (opcode == OpSystem);
      use_rd  = !((opcode == OpStore) || (opcode == OpBranch));
      // RV32E has no x16-x31: any used field with its top bit set is out of range
      bad_reg = (REG_W == 4) && ((use_rd && ins[11]) || (!no_rs1 && ins[19]) ||
                                 (use_rs2 && ins[24]));
      dec.illegal = !known || bad_reg;
      if (dec.illegal) dec.ctrl = '0;
    end
`else
    dec.illegal = 1'b0;
`endif
  end

  // Main/skid buffer
  bundle_t main_q, skid_q;
  logic    main_valid_q, skid_valid_q;
  logic    in_fire, main_free;

  assign in_fire   = bus.i_valid && !skid_valid_q && !bus.i_flush;
  assign main_free = !main_valid_q || bus.i_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (bus.i_flush) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_q       <= skid_q;
        main_valid_q <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        main_valid_q <= in_fire;
        if (in_fire) main_q <= dec;
      end
    end else if (in_fire) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  assign bus.o_ready    = !skid_valid_q;
  assign bus.o_valid    = main_valid_q;
  assign bus.o_pc       = main_q.pc;
  assign bus.o_imm      = main_q.imm;
  assign bus.o_rd       = main_q.rd;
  assign bus.o_rs1      = main_q.rs1;
  assign bus.o_rs2      = main_q.rs2;
  assign bus.o_csr_addr = main_q.csr_addr;
  assign bus.o_exu_opt  = main_q.exu_opt;
  assign bus.o_src_sel  = main_q.src_sel;
  assign bus.o_ctrl     = main_q.ctrl;
  assign bus.o_illegal  = main_q.illegal;

endmodule

// File: tb/tb_ysyx_23060124_idu_pipe.sv
// Directed bench for ysyx_23060124_idu_pipe (REG_W=4); illegal-check cases only with
// IDU_ILLEGAL_CHK_EN defined.
module tb_ysyx_23060124_idu_pipe;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

`ifdef IDU_ILLEGAL_CHK_EN
  localparam bit IllEn = 1'b1;
`else
  localparam bit IllEn = 1'b0;
`endif

  always #5 clock = ~clock;

  ysyx_23060124_idu_pipe_if #(.REG_W(4), .PC_W(32)) bus ();

  ysyx_23060124_idu_pipe #(.REG_W(4), .PC_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] imm;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [11:0] csr;
    logic [2:0]  opt;
    logic [1:0]  sel;
    logic [11:0] ctrl;
    logic        ill;
  } vec_t;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bus.i_flush = 1'b0; bus.i_valid = 1'b0; bus.i_ready = 1'b0;
    bus.i_ins = 32'h0; bus.i_pc = 32'h0;
    reset = 1'b1;
    step(); step();
    total++;
    if (bus.o_valid !== 1'b0) begin
      bad++; $display("FAIL reset.o_valid got=%b want=0", bus.o_valid);
    end
    total++;
    if (bus.o_ready !== 1'b1) begin
      bad++; $display("FAIL reset.o_ready got=%b want=1", bus.o_ready);
    end
    total++;
    if ({bus.o_imm, bus.o_ctrl, bus.o_pc, bus.o_src_sel} !== '0) begin
      bad++; $display("FAIL reset.bundle got=%h/%h/%h/%b want=0", bus.o_imm, bus.o_ctrl,
                      bus.o_pc, bus.o_src_sel);
    end
    reset = 1'b0;
    step();
    total++;
    if (bus.o_ready !== 1'b1) begin
      bad++; $display("FAIL reset.ready_after got=%b want=1", bus.o_ready);
    end
  endtask

  task automatic test_decode();
    vec_t v[$];
    v.push_back('{32'h00500093, 32'h00000005, 4'd1, 4'd0, 4'd0, 12'h000, 3'd0, 2'b01, 12'h001, 1'b0});
    v.push_back('{32'h12345137, 32'h12345000, 4'd2, 4'd0, 4'd0, 12'h000, 3'd0, 2'b01, 12'h001, 1'b0});
    v.push_back('{32'h00208463, 32'h00000008, 4'd8, 4'd1, 4'd2, 12'h000, 3'd0, 2'b00, 12'h080, 1'b0});
    v.push_back('{32'h402081B3, 32'h00000000, 4'd3, 4'd1, 4'd2, 12'h000, 3'd0, 2'b00, 12'h005, 1'b0});
    v.push_back('{32'h0020A223, 32'h00000004, 4'd4, 4'd1, 4'd2, 12'h000, 3'd2, 2'b01, 12'h040, 1'b0});
    v.push_back('{32'h010000EF, 32'h00000010, 4'd1, 4'd0, 4'd0, 12'h000, 3'd0, 2'b10, 12'h101, 1'b0});
    v.push_back('{32'h300022F3, 32'h00000000, 4'd5, 4'd0, 4'd0, 12'h300, 3'd6, 2'b00, 12'h003, 1'b0});
    v.push_back('{32'h00000073, 32'h00000000, 4'd0, 4'd0, 4'd0, 12'h000, 3'd0, 2'b00, 12'h010, 1'b0});
    v.push_back('{32'h00100073, 32'h00000000, 4'd0, 4'd0, 4'd0, 12'h001, 3'd0, 2'b00, 12'h400, 1'b0});
    v.push_back('{32'h30200073, 32'h00000000, 4'd0, 4'd0, 4'd0, 12'h302, 3'd0, 2'b00, 12'h008, 1'b0});
    v.push_back('{32'h0000100F, 32'h00000000, 4'd0, 4'd0, 4'd0, 12'h000, 3'd0, 2'b00, 12'h800, 1'b0});
    v.push_back('{32'h4030D093, 32'h00000403, 4'd1, 4'd1, 4'd0, 12'h000, 3'd5, 2'b01, 12'h005, 1'b0});
    v.push_back('{32'hFFC12303, 32'hFFFFFFFC, 4'd6, 4'd2, 4'd0, 12'h000, 3'd2, 2'b01, 12'h021, 1'b0});
    v.push_back('{32'h00100013, 32'h00000001, 4'd0, 4'd0, 4'd0, 12'h000, 3'd0, 2'b01, 12'h000, 1'b0});
    v.push_back('{32'hFFFFFFFF, 32'h00000000, 4'hF, 4'hF, 4'd0, 12'h000, 3'd0, 2'b00, 12'h000, 1'b1});
    bus.i_ready = 1'b1;
    foreach (v[i]) begin
      logic [31:0] pc;
      pc = 32'h8000_0000 + 32'(i) * 4;
      bus.i_valid = 1'b1; bus.i_ins = v[i].ins; bus.i_pc = pc;
      step();
      total++;
      if (bus.o_valid !== 1'b1 || bus.o_pc !== pc) begin
        bad++; $display("FAIL dec[%0d].valid_pc got=%b/%h want=1/%h", i, bus.o_valid, bus.o_pc, pc);
      end
      total++;
      if (bus.o_imm !== v[i].imm) begin
        bad++; $display("FAIL dec[%0d].imm got=%h want=%h", i, bus.o_imm, v[i].imm);
      end
      total++;
      if ({bus.o_rd, bus.o_rs1, bus.o_rs2} !== {v[i].rd, v[i].rs1, v[i].rs2}) begin
        bad++; $display("FAIL dec[%0d].regs got=%h/%h/%h want=%h/%h/%h", i, bus.o_rd, bus.o_rs1,
                        bus.o_rs2, v[i].rd, v[i].rs1, v[i].rs2);
      end
      total++;
      if (bus.o_csr_addr !== v[i].csr) begin
        bad++; $display("FAIL dec[%0d].csr got=%h want=%h", i, bus.o_csr_addr, v[i].csr);
      end
      total++;
      if (bus.o_exu_opt !== v[i].opt || bus.o_src_sel !== v[i].sel) begin
        bad++; $display("FAIL dec[%0d].opt_sel got=%0d/%b want=%0d/%b", i, bus.o_exu_opt,
                        bus.o_src_sel, v[i].opt, v[i].sel);
      end
      total++;
      if (bus.o_ctrl !== v[i].ctrl) begin
        bad++; $display("FAIL dec[%0d].ctrl got=%h want=%h", i, bus.o_ctrl, v[i].ctrl);
      end
      total++;
      if (bus.o_illegal !== (IllEn & v[i].ill)) begin
        bad++; $display("FAIL dec[%0d].illegal got=%b want=%b", i, bus.o_illegal, IllEn & v[i].ill);
      end
    end
    bus.i_valid = 1'b0;
    step();
    total++;
    if (bus.o_valid !== 1'b0) begin
      bad++; $display("FAIL dec.drain got=%b want=0", bus.o_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.i_valid = 1'b1; bus.i_ins = 32'h00500093; bus.i_pc = 32'h1000 + 32'(i) * 4;
      step();
      total++;
      if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b1 || bus.o_pc !== 32'h1000 + 32'(i) * 4)
      begin
        bad++; $display("FAIL b2b[%0d] got=%b/%b/%h want=1/1/%h", i, bus.o_valid, bus.o_ready,
                        bus.o_pc, 32'h1000 + 32'(i) * 4);
      end
    end
    bus.i_valid = 1'b0;
    step();
  endtask

  task automatic test_skid();
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1; bus.i_ins = 32'h00500093; bus.i_pc = 32'hA0;
    step();
    total++;
    if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b1 || bus.o_pc !== 32'hA0) begin
      bad++; $display("FAIL skid.first got=%b/%b/%h want=1/1/a0", bus.o_valid, bus.o_ready, bus.o_pc);
    end
    bus.i_ins = 32'h12345137; bus.i_pc = 32'hB0;
    step();
    total++;
    if (bus.o_ready !== 1'b0 || bus.o_pc !== 32'hA0) begin
      bad++; $display("FAIL skid.full got=%b/%h want=0/a0", bus.o_ready, bus.o_pc);
    end
    bus.i_ins = 32'h00208463; bus.i_pc = 32'hC0;
    step();
    total++;
    if (bus.o_ready !== 1'b0 || bus.o_pc !== 32'hA0 || bus.o_imm !== 32'h5) begin
      bad++; $display("FAIL skid.hold got=%b/%h/%h want=0/a0/5", bus.o_ready, bus.o_pc, bus.o_imm);
    end
    bus.i_ready = 1'b1;
    step();
    total++;
    if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b1 || bus.o_pc !== 32'hB0 ||
        bus.o_imm !== 32'h12345000) begin
      bad++; $display("FAIL skid.second got=%b/%b/%h/%h want=1/1/b0/12345000", bus.o_valid,
                      bus.o_ready, bus.o_pc, bus.o_imm);
    end
    step();
    bus.i_valid = 1'b0;
    total++;
    if (bus.o_valid !== 1'b1 || bus.o_pc !== 32'hC0 || bus.o_ctrl !== 12'h080) begin
      bad++; $display("FAIL skid.third got=%b/%h/%h want=1/c0/080", bus.o_valid, bus.o_pc,
                      bus.o_ctrl);
    end
    step();
    total++;
    if (bus.o_valid !== 1'b0) begin
      bad++; $display("FAIL skid.empty got=%b want=0", bus.o_valid);
    end
  endtask

  task automatic test_flush();
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1; bus.i_ins = 32'h00500093; bus.i_pc = 32'hD0;
    step();
    bus.i_pc = 32'hD4;
    step();
    total++;
    if (bus.o_ready !== 1'b0) begin
      bad++; $display("FAIL flush.setup got=%b want=0", bus.o_ready);
    end
    bus.i_pc = 32'hD8; bus.i_flush = 1'b1;
    step();
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      bad++; $display("FAIL flush.clear got=%b/%b want=0/1", bus.o_valid, bus.o_ready);
    end
    bus.i_flush = 1'b0; bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    step();
    total++;
    if (bus.o_valid !== 1'b0) begin
      bad++; $display("FAIL flush.dropped got=%b/%h want=0", bus.o_valid, bus.o_pc);
    end
  endtask

  task automatic test_reset_mid();
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1; bus.i_ins = 32'h00500093; bus.i_pc = 32'hE0;
    step();
    bus.i_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_pc !== 32'h0 || bus.o_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid got=%b/%h/%b want=0/0/1", bus.o_valid, bus.o_pc, bus.o_ready);
    end
    step();
    reset = 1'b0;
    step();
    total++;
    if (bus.o_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid.after got=%b want=0", bus.o_valid);
    end
  endtask

`ifdef IDU_ILLEGAL_CHK_EN
  task automatic test_illegal();
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1; bus.i_ins = 32'h00000833; bus.i_pc = 32'hF0;
    step();
    bus.i_valid = 1'b0;
    total++;
    if (bus.o_valid !== 1'b1 || bus.o_illegal !== 1'b1 || bus.o_ctrl !== 12'h000) begin
      bad++; $display("FAIL illegal.x16 got=%b/%b/%h want=1/1/000", bus.o_valid, bus.o_illegal,
                      bus.o_ctrl);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_skid();
    test_flush();
    test_reset_mid();
`ifdef IDU_ILLEGAL_CHK_EN
    test_illegal();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
